// File: rtl/gsi_sram_id_ctrl.sv
// Sequencer for the GSI SRAM JTAG ID-read engine: repeats ID reads under busy-handshake
// timeouts and publishes the SRAM type once N_MATCH consecutive reads agree.
module gsi_sram_id_ctrl #(
  parameter int N_MATCH      = 3,
  parameter int MAX_TRIES    = 8,
  parameter int RISE_TIMEOUT = 16,
  parameter int FALL_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_sram_id_rst_n,
  input  logic       i_sys_rdy,
  input  logic       i_rescan,
  output logic       o_id_start,
  input  logic       i_id_busy,
  input  logic [2:0] i_id_code,
  output logic [2:0] o_sram_id,
  output logic [4:0] o_depth_log2,
  output logic       o_id_valid,
  output logic       o_id_fail,
  output logic       o_busy,
  output logic [3:0] o_attempts
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START     = 4'd1;
  localparam logic [3:0] S_WAIT_RISE = 4'd2;
  localparam logic [3:0] S_WAIT_FALL = 4'd3;
  localparam logic [3:0] S_SETTLE    = 4'd4;
  localparam logic [3:0] S_EVAL      = 4'd5;
  localparam logic [3:0] S_ERR       = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_FAIL      = 4'd8;

  localparam logic [2:0] N_MATCH_L = 3'(N_MATCH);
  localparam logic [3:0] MAX_L     = 4'(MAX_TRIES);
  localparam logic [7:0] RISE_L    = 8'(RISE_TIMEOUT);
  localparam logic [7:0] FALL_L    = 8'(FALL_TIMEOUT);

  function automatic logic [4:0] depth_of(input logic [2:0] code);
    case (code)
      3'd4:    depth_of = 5'd24;
      3'd3:    depth_of = 5'd23;
      3'd2:    depth_of = 5'd22;
      3'd1:    depth_of = 5'd21;
      default: depth_of = 5'd0;
    endcase
  endfunction

  logic [3:0] state_q, state_d;
  logic [3:0] attempts_q, attempts_d;
  logic [2:0] match_cnt_q, match_cnt_d;
  logic [2:0] prev_code_q, prev_code_d;
  logic [7:0] timer_q, timer_d;
  logic       settle_q, settle_d;
  logic [2:0] sram_id_q, sram_id_d;
  logic [4:0] depth_q, depth_d;
  logic       valid_q, valid_d;
  logic       fail_q, fail_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;

  logic [2:0] code_clean;
  logic [2:0] match_nxt;
  logic [7:0] timer_inc;

  // Handshake: o_id_start is a one-cycle pulse; the engine answers by raising i_id_busy,
  // and the falling edge of i_id_busy means i_id_code is about to become valid.
  always_comb begin
    code_clean  = (i_id_code > 3'd4) ? 3'd0 : i_id_code;
    match_nxt   = (match_cnt_q == 3'd0 || code_clean == prev_code_q) ? match_cnt_q + 3'd1 : 3'd1;
    timer_inc   = timer_q + 8'd1;
    state_d     = state_q;
    attempts_d  = attempts_q;
    match_cnt_d = match_cnt_q;
    prev_code_d = prev_code_q;
    timer_d     = timer_q;
    settle_d    = settle_q;
    sram_id_d   = sram_id_q;
    depth_d     = depth_q;
    valid_d     = valid_q;
    fail_d      = fail_q;
    if (!i_sys_rdy && state_q != S_DONE && state_q != S_FAIL) begin
      // Losing the clock lock abandons the scan; the next lock starts afresh.
      state_d     = S_IDLE;
      match_cnt_d = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_sys_rdy && !valid_q && !fail_q) begin
            state_d     = S_START;
            attempts_d  = 4'd0;
            match_cnt_d = 3'd0;
            prev_code_d = 3'd0;
          end
        end
        S_START: begin
          attempts_d = attempts_q + 4'd1;
          timer_d    = 8'd0;
          state_d    = S_WAIT_RISE;
        end
        S_WAIT_RISE: begin
          timer_d = timer_inc;
          if (i_id_busy) begin
            state_d = S_WAIT_FALL;
            timer_d = 8'd0;
          end else if (timer_inc == RISE_L) begin
            state_d = S_ERR;
          end
        end
        S_WAIT_FALL: begin
          timer_d = timer_inc;
          if (!i_id_busy) begin
            state_d  = S_SETTLE;
            settle_d = 1'b0;
          end else if (timer_inc == FALL_L) begin
            state_d = S_ERR;
          end
        end
        S_SETTLE: begin
          settle_d = 1'b1;
          if (settle_q) state_d = S_EVAL;
        end
        S_EVAL: begin
          match_cnt_d = match_nxt;
          prev_code_d = code_clean;
          if (match_nxt == N_MATCH_L) begin
            state_d   = S_DONE;
            sram_id_d = code_clean;
            depth_d   = depth_of(code_clean);
            valid_d   = 1'b1;
          end else if (attempts_q == MAX_L) begin
            state_d   = S_FAIL;
            sram_id_d = 3'd0;
            depth_d   = 5'd0;
            fail_d    = 1'b1;
          end else begin
            state_d = S_START;
          end
        end
        S_ERR: begin
          match_cnt_d = 3'd0;
          if (attempts_q == MAX_L) begin
            state_d   = S_FAIL;
            sram_id_d = 3'd0;
            depth_d   = 5'd0;
            fail_d    = 1'b1;
          end else begin
            state_d = S_START;
          end
        end
        S_DONE, S_FAIL: begin
          if (i_rescan) begin
            state_d   = S_IDLE;
            valid_d   = 1'b0;
            fail_d    = 1'b0;
            sram_id_d = 3'd0;
            depth_d   = 5'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_FAIL);
  end

  always_ff @(posedge i_clk or negedge i_sram_id_rst_n) begin
    if (!i_sram_id_rst_n) begin
      state_q     <= S_IDLE;
      attempts_q  <= 4'd0;
      match_cnt_q <= 3'd0;
      prev_code_q <= 3'd0;
      timer_q     <= 8'd0;
      settle_q    <= 1'b0;
      sram_id_q   <= 3'd0;
      depth_q     <= 5'd0;
      valid_q     <= 1'b0;
      fail_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      attempts_q  <= attempts_d;
      match_cnt_q <= match_cnt_d;
      prev_code_q <= prev_code_d;
      timer_q     <= timer_d;
      settle_q    <= settle_d;
      sram_id_q   <= sram_id_d;
      depth_q     <= depth_d;
      valid_q     <= valid_d;
      fail_q      <= fail_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  assign o_id_start   = start_q;
  assign o_busy       = busy_q;
  assign o_attempts   = attempts_q;
  assign o_sram_id    = sram_id_q;
  assign o_depth_log2 = depth_q;
  assign o_id_valid   = valid_q;
  assign o_id_fail    = fail_q;

endmodule

// File: tb/tb_gsi_sram_id_ctrl.sv
// Bench for gsi_sram_id_ctrl: a cycle-level ID-engine model, a table of read-outcome
// scripts, hand-written timing sequences and randomized scans against a scan-level model.
module tb_gsi_sram_id_ctrl;
  localparam int N_MATCH = 3, MAX_TRIES = 8, RISE_TO = 16, FALL_TO = 255;

  logic       clk = 1'b0, rst_n = 1'b0, sys_rdy = 1'b0, rescan = 1'b0;
  logic       id_busy = 1'b0;
  logic [2:0] id_code = 3'd0;
  logic       o_id_start, o_id_valid, o_id_fail, o_busy;
  logic [2:0] o_sram_id;
  logic [4:0] o_depth_log2;
  logic [3:0] o_attempts;

  gsi_sram_id_ctrl #(.N_MATCH(N_MATCH), .MAX_TRIES(MAX_TRIES), .RISE_TIMEOUT(RISE_TO),
                     .FALL_TIMEOUT(FALL_TO)) dut (
    .i_clk(clk), .i_sram_id_rst_n(rst_n), .i_sys_rdy(sys_rdy), .i_rescan(rescan),
    .o_id_start(o_id_start), .i_id_busy(id_busy), .i_id_code(id_code),
    .o_sram_id(o_sram_id), .o_depth_log2(o_depth_log2), .o_id_valid(o_id_valid),
    .o_id_fail(o_id_fail), .o_busy(o_busy), .o_attempts(o_attempts));

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0][2:0] code; logic [7:0] to;
    logic v; logic f; logic [2:0] id; logic [4:0] dep; logic [3:0] att;
  } vec_t;
  typedef struct packed { logic v; logic f; logic [2:0] id; logic [4:0] dep; logic [3:0] att; } res_t;

  int n_checks = 0, n_fail = 0;
  logic [2:0] resp_code[8];
  bit         resp_to[8];
  int busy_len = 4, rise_dly = 1, scan_base = 0, kill_req = 0;
  int n_starts = 0;
  int start_cyc[$];

  // ID-engine model: 1 cycle after a start pulse raises busy for busy_len cycles,
  // then presents the scripted code; a scripted timeout never raises busy.
  initial begin
    int dly_cnt, bsy_cnt, kill_seen, idx;
    logic [2:0] cur_code;
    dly_cnt = 0; bsy_cnt = 0; kill_seen = 0; cur_code = 3'd0;
    forever begin
      @(posedge clk); #1;
      if (kill_req != kill_seen) begin
        kill_seen = kill_req; dly_cnt = 0; bsy_cnt = 0; id_busy = 1'b0; id_code = 3'd0;
      end
      if (dly_cnt > 0) begin
        dly_cnt--;
        if (dly_cnt == 0) begin id_busy = 1'b1; bsy_cnt = busy_len; end
      end else if (bsy_cnt > 0) begin
        bsy_cnt--;
        if (bsy_cnt == 0) begin id_busy = 1'b0; id_code = cur_code; end
      end
      if (o_id_start === 1'b1) begin
        start_cyc.push_back(cyc);
        idx = n_starts - scan_base;
        if (idx >= 0 && idx < 8 && !resp_to[idx]) begin dly_cnt = rise_dly; cur_code = resp_code[idx]; end
        n_starts++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sys_rdy = 1'b0; rescan = 1'b0; kill_req++;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 8; i++) begin resp_code[i] = v.code[i]; resp_to[i] = v.to[i]; end
  endtask

  task automatic start_scan();
    scan_base = n_starts; sys_rdy = 1'b1;
  endtask

  task automatic pulse_rescan();
    rescan = 1'b1; tick(1); rescan = 1'b0;
  endtask

  task automatic wait_result(input string tag, output int done_cyc);
    int i;
    i = 0;
    while (!(o_id_valid || o_id_fail) && i < 3000) begin tick(1); i++; end
    done_cyc = cyc;
    check({tag, "_finished"}, 32'(o_id_valid | o_id_fail), 1);
  endtask

  task automatic wait_starts(input int n, input int limit);
    int i;
    i = 0;
    while (n_starts - scan_base < n && i < limit) begin tick(1); i++; end
    check("start_wait", 32'(n_starts - scan_base), 32'(n));
  endtask

  // '0'..'7' is a returned code, 't' a read whose busy never rises
  function automatic vec_t mk(input string s, input logic v, input logic f, input logic [2:0] id,
                              input logic [4:0] dep, input logic [3:0] att);
    vec_t t;
    byte ch;
    t = '0; t.to = '1;
    for (int i = 0; i < s.len() && i < 8; i++) begin
      ch = s.getc(i);
      if (ch == 8'h74) t.to[i] = 1'b1;
      else begin t.to[i] = 1'b0; t.code[i] = ch[2:0]; end
    end
    t.v = v; t.f = f; t.id = id; t.dep = dep; t.att = att;
    return t;
  endfunction

  // Scan-level reference: walk the scripted reads counting the run of equal codes.
  function automatic res_t model();
    res_t r;
    int run;
    logic [2:0] prev, c;
    r = '0; run = 0; prev = 3'd0;
    for (int a = 1; a <= MAX_TRIES; a++) begin
      if (resp_to[a-1]) run = 0;
      else begin
        c = resp_code[a-1];
        if (c > 3'd4) c = 3'd0;
        run = (run > 0 && c == prev) ? run + 1 : 1;
        prev = c;
        if (run == N_MATCH) begin
          r.v = 1'b1; r.id = c; r.dep = (c == 3'd0) ? 5'd0 : 5'(20 + c); r.att = 4'(a);
          return r;
        end
      end
    end
    r.f = 1'b1; r.att = 4'(MAX_TRIES);
    return r;
  endfunction

  task automatic check_result(input string tag, input logic v, input logic f, input logic [2:0] id,
                              input logic [4:0] dep, input logic [3:0] att);
    check({tag, "_valid"}, 32'(o_id_valid), 32'(v));
    check({tag, "_fail"}, 32'(o_id_fail), 32'(f));
    check({tag, "_id"}, 32'(o_sram_id), 32'(id));
    check({tag, "_depth"}, 32'(o_depth_log2), 32'(dep));
    check({tag, "_attempts"}, 32'(o_attempts), 32'(att));
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_starts"}, 32'(n_starts - scan_base), 32'(att));
  endtask

  vec_t vecs[10];
  res_t exp_r;

  initial begin
    int dc, base;
    logic [2:0] pc;
    vecs[0] = mk("444",      1, 0, 3'd4, 5'd24, 4'd3);
    vecs[1] = mk("22333",    1, 0, 3'd3, 5'd23, 4'd5);
    vecs[2] = mk("tttttttt", 0, 1, 3'd0, 5'd0,  4'd8);
    vecs[3] = mk("777",      1, 0, 3'd0, 5'd0,  4'd3);
    vecs[4] = mk("111",      1, 0, 3'd1, 5'd21, 4'd3);
    vecs[5] = mk("000",      1, 0, 3'd0, 5'd0,  4'd3);
    vecs[6] = mk("12121212", 0, 1, 3'd0, 5'd0,  4'd8);
    vecs[7] = mk("t44t444",  1, 0, 3'd4, 5'd24, 4'd7);
    vecs[8] = mk("500",      1, 0, 3'd0, 5'd0,  4'd3);
    vecs[9] = mk("tttttt22", 0, 1, 3'd0, 5'd0,  4'd8);

    // reset state
    tick(2);
    check("rst_start", 32'(o_id_start), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_valid", 32'(o_id_valid), 0);
    check("rst_fail", 32'(o_id_fail), 0);
    check("rst_id", 32'(o_sram_id), 0);
    check("rst_depth", 32'(o_depth_log2), 0);
    check("rst_attempts", 32'(o_attempts), 0);

    // table-driven scans
    foreach (vecs[k]) begin
      load(vecs[k]); busy_len = 4;
      do_reset(); start_scan();
      wait_result($sformatf("vec%0d", k), dc);
      tick(3);
      check_result($sformatf("vec%0d", k), vecs[k].v, vecs[k].f, vecs[k].id, vecs[k].dep, vecs[k].att);
    end

    // start latency, start spacing and DONE timing with a 100-cycle busy
    load(mk("444", 1, 0, 3'd4, 5'd24, 4'd3)); busy_len = 100;
    do_reset(); base = cyc; start_scan();
    wait_result("t1", dc);
    check("t1_first_start", 32'(start_cyc[n_starts-3]), 32'(base + 1));
    check("t1_gap1", 32'(start_cyc[n_starts-2] - start_cyc[n_starts-3]), 32'(busy_len + 5));
    check("t1_gap2", 32'(start_cyc[n_starts-1] - start_cyc[n_starts-2]), 32'(busy_len + 5));
    check("t1_done_cyc", 32'(dc), 32'(start_cyc[n_starts-1] + busy_len + 5));
    tick(3);
    check_result("t1", 1, 0, 3'd4, 5'd24, 4'd3);

    // busy never rises: start pulses spaced RISE_TO+2
    load(mk("tttttttt", 0, 1, 3'd0, 5'd0, 4'd8)); busy_len = 4;
    do_reset(); start_scan();
    wait_result("t2", dc);
    for (int i = 1; i < 8; i++)
      check($sformatf("t2_gap%0d", i), 32'(start_cyc[n_starts-8+i] - start_cyc[n_starts-9+i]), 32'(RISE_TO + 2));

    // busy stuck high: fall timeout then retry
    load(mk("4ttttttt", 0, 1, 3'd0, 5'd0, 4'd8)); busy_len = 300;
    do_reset(); start_scan();
    wait_starts(2, 400);
    check("t3_fall_gap", 32'(start_cyc[n_starts-1] - start_cyc[n_starts-2]), 32'(FALL_TO + 3));
    check("t3_attempts", 32'(o_attempts), 1);

    // asynchronous reset mid-scan
    rst_n = 1'b0; #1;
    check("arst_busy", 32'(o_busy), 0);
    check("arst_start", 32'(o_id_start), 0);
    check("arst_attempts", 32'(o_attempts), 0);

    // sys_rdy drops during the second WAIT_FALL, then comes back
    load(mk("44444444", 1, 0, 3'd4, 5'd24, 4'd3)); busy_len = 20;
    do_reset(); start_scan();
    wait_starts(2, 200);
    tick(6);
    sys_rdy = 1'b0;
    tick(1);
    check("abort_busy", 32'(o_busy), 0);
    tick(40);
    check("abort_no_start", 32'(n_starts - scan_base), 2);
    check("abort_valid", 32'(o_id_valid), 0);
    start_scan();
    tick(2);
    check("rerun_att1", 32'(o_attempts), 1);
    wait_result("rerun", dc);
    tick(3);
    check_result("rerun", 1, 0, 3'd4, 5'd24, 4'd3);

    // 1-cycle busy glitch, code 111 forced to 000, rescan mid-scan ignored
    load(mk("777", 1, 0, 3'd0, 5'd0, 4'd3)); busy_len = 1;
    do_reset(); start_scan();
    wait_starts(2, 200);
    pulse_rescan();
    wait_result("glitch", dc);
    tick(3);
    check_result("glitch", 1, 0, 3'd0, 5'd0, 4'd3);
    sys_rdy = 1'b0;
    tick(5);
    check("hold_valid", 32'(o_id_valid), 1);
    check("hold_attempts", 32'(o_attempts), 3);

    // DONE with 001, rescan, engine now reports no SRAM
    load(mk("111", 1, 0, 3'd1, 5'd21, 4'd3)); busy_len = 4;
    do_reset(); start_scan();
    wait_result("r1", dc);
    tick(3);
    check_result("r1", 1, 0, 3'd1, 5'd21, 4'd3);
    load(mk("000", 1, 0, 3'd0, 5'd0, 4'd3));
    scan_base = n_starts;
    pulse_rescan();
    check("r2_clr_valid", 32'(o_id_valid), 0);
    check("r2_clr_depth", 32'(o_depth_log2), 0);
    wait_result("r2", dc);
    tick(3);
    check_result("r2", 1, 0, 3'd0, 5'd0, 4'd3);

    // randomized scans, each restarted by rescan
    for (int r = 0; r < 25; r++) begin
      pc = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) begin
        resp_to[i] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 2) == 0) pc = 3'($urandom_range(0, 7));
        resp_code[i] = pc;
      end
      busy_len = $urandom_range(1, 12);
      exp_r = model();
      scan_base = n_starts;
      pulse_rescan();
      check("rnd_clr_valid", 32'(o_id_valid), 0);
      check("rnd_clr_fail", 32'(o_id_fail), 0);
      wait_result("rnd", dc);
      tick(3);
      check_result($sformatf("rnd%0d", r), exp_r.v, exp_r.f, exp_r.id, exp_r.dep, exp_r.att);
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
